mem_access: RTL and testbench

- MEM pipeline stage plus MEM/WB pipeline register.
- Consumes the 72-bit ex_mem bundle from the execute stage.
- Performs load/store via a ready/request handshake to an external data memory.
- Produces the registered 71-bit mem_wb bundle consumed directly by write_back. Stalls upstream while a memory access is outstanding.

---
 rtl/mem_access.sv | 153 +++++++++++++++
 tb/tb_mem_access.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage with MEM/WB register: issues loads/stores over a req/ready handshake.
// Optional MEM_MISALIGN_CHECK_EN adds a registered misalign pulse and suppresses unaligned accesses.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [71:0] ex_mem,
  input  logic        ex_mem_valid,
  input  logic        flush,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic [70:0] mem_wb
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [CNT_W-1:0] LpCntLast =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_mem_err;
  logic [70:0]       r_mem_wb;
  logic [4:0]        r_rd_l;
  logic [31:0]       r_alu_l;
  logic              r_reg_write_l;
  logic              r_is_load_l;
`ifdef MEM_MISALIGN_CHECK_EN
  logic              r_misalign;
`endif

  logic w_take;
  logic w_mem_op;
  logic w_misal;
  logic w_issue;
  logic w_timeout;
  logic w_stall;

  assign w_take   = ex_mem_valid && !flush;
  assign w_mem_op = ex_mem[70] || ex_mem[71];
`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misal  = (ex_mem[6:5] != 2'b00);
`else
  assign w_misal  = 1'b0;
`endif
  assign w_issue   = (r_state == StIdle) && w_take && w_mem_op && !w_misal;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LpCntLast) && !dmem_ready;

  always_comb begin
    w_stall = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StIdle:   w_stall = w_issue;
        StAccess: w_stall = !dmem_ready && !w_timeout;
        default:  w_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_mem_err     <= 1'b0;
      r_mem_wb      <= '0;
      r_rd_l        <= '0;
      r_alu_l       <= '0;
      r_reg_write_l <= 1'b0;
      r_is_load_l   <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_mem_err <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_rd_l        <= ex_mem[4:0];
            r_alu_l       <= ex_mem[36:5];
            r_reg_write_l <= ex_mem[69];
            // Both read and write set is treated as a store.
            r_is_load_l   <= ex_mem[70] && !ex_mem[71];
            r_req         <= 1'b1;
            r_we          <= ex_mem[71];
            r_addr        <= {ex_mem[36:7], 2'b00};
            r_wdata       <= ex_mem[68:37];
            r_mem_wb      <= '0;
            r_cnt         <= '0;
            r_state       <= StAccess;
          end else if (w_take && !w_mem_op) begin
            r_mem_wb <= {1'b0, ex_mem[69], 32'b0, ex_mem[36:0]};
          end else begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (w_take && w_mem_op) r_misalign <= 1'b1;
`endif
            r_mem_wb <= '0;
          end
        end
        StAccess: begin
          if (dmem_ready) begin
            r_mem_wb <= {r_is_load_l, r_reg_write_l, r_is_load_l ? dmem_rdata : 32'b0,
                         r_alu_l, r_rd_l};
            r_req    <= 1'b0;
            r_state  <= StIdle;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_mem_err <= 1'b1;
            r_mem_wb  <= '0;
            r_state   <= StIdle;
          end else begin
            r_mem_wb <= '0;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign mem_stall  = w_stall;
  assign mem_err    = r_mem_err;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_wb     = r_mem_wb;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign   = r_misalign;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected mem_wb words, a monitor pops them.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] ex_mem;
  logic        ex_mem_valid;
  logic        flush;
  logic        mem_stall;
  logic        mem_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [70:0] mem_wb;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [70:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .ex_mem      (ex_mem),
    .ex_mem_valid(ex_mem_valid),
    .flush       (flush),
    .mem_stall   (mem_stall),
    .mem_err     (mem_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign    (misalign),
`endif
    .mem_wb      (mem_wb)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // {wr, rd, reg_write, data, alu, rd_idx}
  function automatic logic [71:0] mk(input logic wr, input logic rdop, input logic rw,
                                     input logic [31:0] d, input logic [31:0] a,
                                     input logic [4:0] r);
    return {wr, rdop, rw, d, a, r};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: any non-bubble mem_wb must match the oldest expected word.
  always @(negedge clk) begin
    if (mem_wb !== '0) begin
      if (exp_q.size() == 0) begin
        chk("mem_wb_unexpected", {1'b0, mem_wb}, 72'd0);
      end else begin
        chk("mem_wb", {1'b0, mem_wb}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int st;
    int k;
    bit seen;
    rst = 1'b1; ex_mem_valid = 1'b0; flush = 1'b0; dmem_rdata = '0; dmem_ready = 1'b0;
    ex_mem = '0;

    // Reset with a live load presented: no stall, outputs zero
    tick(); ex_mem = mk(0, 1, 1, 32'h0, 32'h100, 5'd1); ex_mem_valid = 1'b1;
    tick(); #1;
    chk("rst_stall", {71'd0, mem_stall}, 72'd0);
    chk("rst_mem_wb", {1'b0, mem_wb}, 72'd0);
    chk("rst_req", {71'd0, dmem_req}, 72'd0);
    chk("rst_err", {71'd0, mem_err}, 72'd0);

    // ALU op
    tick(); rst = 1'b0; ex_mem = mk(0, 0, 1, 32'h0, 32'hAA, 5'd5); #1;
    chk("alu_stall", {71'd0, mem_stall}, 72'd0);
    exp_q.push_back({1'b0, 1'b1, 32'h0, 32'hAA, 5'd5});
    tick(); ex_mem_valid = 1'b0; #1;
    chk("alu_stall2", {71'd0, mem_stall}, 72'd0);

    // Load 0x100, ready after 3 wait cycles
    tick(); ex_mem = mk(0, 1, 1, 32'h0, 32'h100, 5'd7); ex_mem_valid = 1'b1; #1;
    st = mem_stall ? 1 : 0;
    exp_q.push_back({1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 5'd7});
    tick(); ex_mem_valid = 1'b0; #1;
    chk("ld_req", {71'd0, dmem_req}, 72'd1);
    chk("ld_addr", {40'd0, dmem_addr}, 72'h100);
    chk("ld_we", {71'd0, dmem_we}, 72'd0);
    st += mem_stall ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1; st += mem_stall ? 1 : 0;
    end
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
    st += mem_stall ? 1 : 0;
    chk("ld_stall_cycles", 72'(st), 72'd4);
    tick(); dmem_ready = 1'b0; dmem_rdata = '0; #1;
    chk("ld_req_drop", {71'd0, dmem_req}, 72'd0);

    // Store with read+write both set, unaligned alu 0x106 -> word address 0x104
`ifndef MEM_MISALIGN_CHECK_EN
    tick(); ex_mem = mk(1, 1, 0, 32'h12345678, 32'h106, 5'd3); ex_mem_valid = 1'b1; #1;
    chk("st_stall", {71'd0, mem_stall}, 72'd1);
    exp_q.push_back({1'b0, 1'b0, 32'h0, 32'h106, 5'd3});
    tick(); ex_mem_valid = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF; #1;
    chk("st_we", {71'd0, dmem_we}, 72'd1);
    chk("st_wdata", {40'd0, dmem_wdata}, 72'h12345678);
    chk("st_addr", {40'd0, dmem_addr}, 72'h104);
    chk("st_stall_ready", {71'd0, mem_stall}, 72'd0);
    tick(); dmem_ready = 1'b0; dmem_rdata = '0;
`else
    tick(); ex_mem = mk(0, 1, 1, 32'h0, 32'h102, 5'd4); ex_mem_valid = 1'b1; #1;
    chk("mis_stall", {71'd0, mem_stall}, 72'd0);
    tick(); ex_mem_valid = 1'b0; #1;
    chk("mis_pulse", {71'd0, misalign}, 72'd1);
    chk("mis_req", {71'd0, dmem_req}, 72'd0);
    tick(); #1;
    chk("mis_pulse_end", {71'd0, misalign}, 72'd0);
`endif

    // Load that never sees ready: timeout after 16 access cycles
    tick(); ex_mem = mk(0, 1, 1, 32'h0, 32'h200, 5'd9); ex_mem_valid = 1'b1;
    tick(); ex_mem_valid = 1'b0;
    st = 0; seen = 1'b0; k = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) tick();
      #1;
      if (mem_err) begin
        seen = 1'b1; k = i; break;
      end
      st += mem_stall ? 1 : 0;
    end
    chk("to_seen", {71'd0, seen}, 72'd1);
    chk("to_latency", 72'(k), 72'd17);
    chk("to_stall_cycles", 72'(st), 72'd15);
    chk("to_req", {71'd0, dmem_req}, 72'd0);
    tick(); #1;
    chk("to_err_pulse", {71'd0, mem_err}, 72'd0);

    // Flush in IDLE drops the load
    tick(); ex_mem = mk(0, 1, 1, 32'h0, 32'h300, 5'd2); ex_mem_valid = 1'b1; flush = 1'b1; #1;
    chk("fl_stall", {71'd0, mem_stall}, 72'd0);
    tick(); ex_mem_valid = 1'b0; flush = 1'b0; #1;
    chk("fl_req", {71'd0, dmem_req}, 72'd0);
    chk("fl_mem_wb", {1'b0, mem_wb}, 72'd0);

    // dmem_ready in IDLE is ignored
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'h55AA55AA;
    tick(); dmem_ready = 1'b0; #1;
    chk("idle_ready_wb", {1'b0, mem_wb}, 72'd0);

    // Reset mid-ACCESS with ready asserted: nothing written back
    tick(); ex_mem = mk(1, 0, 1, 32'hCAFEF00D, 32'h300, 5'd6); ex_mem_valid = 1'b1;
    tick(); ex_mem_valid = 1'b0; #1;
    chk("rma_req", {71'd0, dmem_req}, 72'd1);
    tick(); rst = 1'b1; dmem_ready = 1'b1; #1;
    chk("rma_stall", {71'd0, mem_stall}, 72'd0);
    tick(); rst = 1'b0; dmem_ready = 1'b0; #1;
    chk("rma_req0", {71'd0, dmem_req}, 72'd0);
    chk("rma_we0", {71'd0, dmem_we}, 72'd0);
    chk("rma_addr0", {40'd0, dmem_addr}, 72'd0);
    chk("rma_wdata0", {40'd0, dmem_wdata}, 72'd0);
    chk("rma_mem_wb", {1'b0, mem_wb}, 72'd0);

    tick(); tick();
    chk("sb_drained", 72'(exp_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
